// File: rtl/fc_layer_sequencer_if.sv
// Handshake and operand bus between the layer scheduler, the FC sequencer and
// the FC datapath / weight memory.
interface fc_layer_sequencer_if #(
    parameter int IDX_WIDTH = 7
);
    logic                 start;
    logic                 stall;
    logic                 busy;
    logic                 pe_clear;
    logic                 in_valid;
    logic [IDX_WIDTH-1:0] in_idx;
    logic [IDX_WIDTH-1:0] wt_addr;
    logic                 out_valid;
    logic                 out_ready;
    logic                 done;

    // Scheduler / datapath side: issues requests, reports stalls, consumes result.
    modport master (
        output start, stall, out_ready,
        input  busy, pe_clear, in_valid, in_idx, wt_addr, out_valid, done
    );

    // Sequencer side.
    modport slave (
        input  start, stall, out_ready,
        output busy, pe_clear, in_valid, in_idx, wt_addr, out_valid, done
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Control FSM for one fully connected layer pass: clear accumulators, stream
// operands from index N-1 down to 0, wait out the PE pipeline, then hold the
// result until the consumer takes it.
module fc_layer_sequencer #(
    parameter int INPUT_NEURONS = 100,
    parameter int IDX_WIDTH     = 7,
    parameter int PE_LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fc_layer_sequencer_if.slave  bus
);

    localparam int CNT_WIDTH = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(INPUT_NEURONS - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_pe_clear;
    logic [IDX_WIDTH-1:0] r_in_idx;
    logic [CNT_WIDTH-1:0] r_drain_cnt;
    logic                 r_out_valid;
    logic                 r_done;

    state_t               w_state_next;
    logic                 w_busy_next;
    logic                 w_pe_clear_next;
    logic [IDX_WIDTH-1:0] w_in_idx_next;
    logic [CNT_WIDTH-1:0] w_drain_cnt_next;
    logic                 w_out_valid_next;
    logic                 w_done_next;

    // State and registered outputs; reset aborts any pass without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_pe_clear  <= 1'b0;
            r_in_idx    <= '0;
            r_drain_cnt <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= w_busy_next;
            r_pe_clear  <= w_pe_clear_next;
            r_in_idx    <= w_in_idx_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_out_valid <= w_out_valid_next;
            r_done      <= w_done_next;
        end
    end

    // Next-state and next-output decode; pe_clear and done are single-cycle pulses.
    always_comb begin
        w_state_next     = r_state;
        w_busy_next      = r_busy;
        w_pe_clear_next  = 1'b0;
        w_in_idx_next    = r_in_idx;
        w_drain_cnt_next = r_drain_cnt;
        w_out_valid_next = r_out_valid;
        w_done_next      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Also covers the done cycle, so back-to-back passes need no gap.
                if (bus.start) begin
                    w_state_next    = S_CLEAR;
                    w_busy_next     = 1'b1;
                    w_pe_clear_next = 1'b1;
                end
            end
            S_CLEAR: begin
                w_state_next  = S_FEED;
                w_in_idx_next = LAST_IDX;
            end
            S_FEED: begin
                // A stalled cycle consumes nothing: index and state both hold.
                if (!bus.stall) begin
                    if (r_in_idx == '0) begin
                        w_state_next     = S_DRAIN;
                        w_drain_cnt_next = '0;
                    end else begin
                        w_in_idx_next = r_in_idx - IDX_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == LAST_CNT) begin
                    w_state_next     = S_HOLD;
                    w_out_valid_next = 1'b1;
                end else begin
                    w_drain_cnt_next = r_drain_cnt + CNT_WIDTH'(1);
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_next     = S_IDLE;
                    w_out_valid_next = 1'b0;
                    w_busy_next      = 1'b0;
                    w_done_next      = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = r_busy;
    assign bus.pe_clear  = r_pe_clear;
    // in_valid follows stall within the cycle so a stalled cycle never
    // advertises an operand to the PE array.
    assign bus.in_valid  = (r_state == S_FEED) && !bus.stall;
    assign bus.in_idx    = r_in_idx;
    assign bus.wt_addr   = r_in_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.done      = r_done;

endmodule
